fpmul_rr_arbiter: RTL and testbench

//   Shares one multi-cycle multiplier_fp (start/busy/ready, 32-bit A/B/Y) among N_REQ vector-lane requesters.

---
 rtl/fpmul_rr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fpmul_rr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_rr_arbiter.sv
// rtl/fpmul_rr_arbiter.sv - round-robin arbiter sharing one multi-cycle FP multiplier (optional FPMUL_ZERO_BYPASS_EN)
module fpmul_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int IDW   = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_y,
  input  logic               rsp_ready,
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic               mul_busy,
  input  logic               mul_ready,
  input  logic [W-1:0]       mul_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [IDW-1:0] C_LAST = IDW'(N_REQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic               r_seen_busy;
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [W-1:0]       r_rsp_y;
  logic [W-1:0]       r_mul_a;
  logic [W-1:0]       r_mul_b;

  logic [N_REQ-1:0]   w_rot;
  logic [IDW-1:0]     w_grant_idx;
  logic [IDW-1:0]     w_ptr_nxt;
  logic               w_grant_en;
  logic               w_capture;
  logic               w_mul_start;
  logic [N_REQ-1:0]   w_req_ready;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;

`ifdef FPMUL_ZERO_BYPASS_EN
  logic               w_bypass;
  logic [7:0]         w_exp_a;
  logic [7:0]         w_exp_b;
`endif

  // Rotate the request vector so bit 0 is the requester the pointer names
  assign w_rot = N_REQ'({req_valid, req_valid} >> r_ptr);

  // First pending requester at or after the pointer, wrapping back to 0
  always_comb begin
    int t;
    w_grant_idx = '0;
    t = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        t = int'(r_ptr) + k;
        if (t >= N_REQ) t = t - N_REQ;
        w_grant_idx = IDW'(t);
      end
    end
  end

  // Operand mux for the lane about to be granted
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

`ifdef FPMUL_ZERO_BYPASS_EN
  // Zero/denormal times finite is a signed zero; NaN/Inf still go to the multiplier
  assign w_exp_a  = w_sel_a[W-2 -: 8];
  assign w_exp_b  = w_sel_b[W-2 -: 8];
  assign w_bypass = ((w_exp_a == 8'h00) || (w_exp_b == 8'h00)) &&
                    (w_exp_a != 8'hFF) && (w_exp_b != 8'hFF);
`endif

  // Only one operation in flight; the multiplier being busy also blocks grants
  assign w_grant_en = (r_state == S_IDLE) && (|req_valid) && !mul_busy;

  // Ready from the multiplier counts only once busy has been observed for this op
  assign w_capture  = r_seen_busy && mul_ready && !mul_busy;

  assign w_ptr_nxt  = (w_grant_idx == C_LAST) ? '0 : w_grant_idx + 1'b1;

  // Next-state and combinational handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_en) begin
          w_req_ready[w_grant_idx] = 1'b1;
`ifdef FPMUL_ZERO_BYPASS_EN
          w_state_nxt = w_bypass ? S_RESP : S_ISSUE;
`else
          w_state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        w_mul_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_capture) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath: pointer, operand capture, busy tracking and response holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_seen_busy <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_ptr    <= w_ptr_nxt;
            r_rsp_id <= w_grant_idx;
`ifdef FPMUL_ZERO_BYPASS_EN
            if (w_bypass) begin
              r_rsp_y     <= {w_sel_a[W-1] ^ w_sel_b[W-1], {(W-1){1'b0}}};
              r_rsp_valid <= 1'b1;
            end else begin
              r_mul_a <= w_sel_a;
              r_mul_b <= w_sel_b;
            end
`else
            r_mul_a <= w_sel_a;
            r_mul_b <= w_sel_b;
`endif
          end
        end
        S_ISSUE: begin
          r_seen_busy <= 1'b0;
        end
        S_WAIT: begin
          if (mul_busy) r_seen_busy <= 1'b1;
          if (w_capture) begin
            r_rsp_y     <= mul_y;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = rst_n ? w_req_ready : '0;
  assign mul_start = w_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// tb/tb_fpmul_rr_arbiter.sv - scoreboard bench for fpmul_rr_arbiter with a behavioural 8-cycle multiplier
module tb_fpmul_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_y;
  logic         rsp_ready = 1'b1;
  logic         mul_start;
  logic [31:0]  mul_a, mul_b;
  logic         mul_busy, mul_ready;
  logic [31:0]  mul_y;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  logic [1:0]  exp_id[$];
  logic [31:0] exp_y[$];

  logic        m_busy, m_ready, m_pend;
  logic [31:0] m_y, m_a, m_b;
  int          m_cnt;
  bit          force_busy = 1'b0;

  always #5 clk = ~clk;

  fpmul_rr_arbiter #(.N_REQ(4), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_ready(mul_ready), .mul_y(mul_y)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40200000) return 32'h41700000;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'h40A00000) return 32'h40A00000;
    if (a == 32'h00000000 && b == 32'hC0400000) return 32'h80000000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // Behavioural multiplier: one idle cycle after start, 8 busy cycles, ready held until next start
  assign mul_busy = m_busy | force_busy;
  assign mul_ready = m_ready;
  assign mul_y = m_y;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
      m_y <= '0; m_a <= '0; m_b <= '0;
    end else if (mul_start) begin
      m_pend <= 1'b1; m_a <= mul_a; m_b <= mul_b;
    end else if (m_pend) begin
      m_pend <= 1'b0; m_busy <= 1'b1; m_ready <= 1'b0; m_cnt <= 8;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_y <= fmul(m_a, m_b);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) if (mul_start === 1'b1) n_starts <= n_starts + 1;

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic collect(output bit ok, output logic [1:0] id, output logic [31:0] y);
    ok = 1'b0; id = '0; y = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; id = rsp_id; y = rsp_y; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_id.delete(); exp_y.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    n_vec++; if (rsp_y !== 32'h0) begin n_err++; $display("FAIL rst_rsp_y: got %h want 0", rsp_y); end
    n_vec++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL rst_mul_start: got %b want 0", mul_start); end
    n_vec++; if ({mul_a, mul_b} !== 64'h0) begin n_err++; $display("FAIL rst_mul_ab: got %h want 0", {mul_a, mul_b}); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; logic [1:0] id; logic [31:0] y; int s0;
    @(negedge clk);
    s0 = n_starts;
    req_a[31:0] = 32'h40C00000; req_b[31:0] = 32'h40200000; req_valid = 4'b0001;
    exp_id.push_back(2'd0); exp_y.push_back(32'h41700000);
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0001) begin n_err++; $display("FAIL t1_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    n_vec++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL t1_start: got %b want 1", mul_start); end
    n_vec++; if ({mul_a, mul_b} !== {32'h40C00000, 32'h40200000}) begin n_err++; $display("FAIL t1_operands: got %h want 40c0000040200000", {mul_a, mul_b}); end
    collect(ok, id, y);
    n_vec++;
    if (!ok || exp_id.size() == 0) begin n_err++; $display("FAIL t1_rsp: got no response want one"); end
    else begin
      logic [1:0] ei; logic [31:0] ey;
      ei = exp_id.pop_front(); ey = exp_y.pop_front();
      if (id !== ei || y !== ey) begin n_err++; $display("FAIL t1_rsp: got id %0d y %h want id %0d y %h", id, y, ei, ey); end
    end
    @(negedge clk);
    n_vec++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL t1_start_count: got %0d want 1", n_starts - s0); end
  endtask

  task automatic test_round_robin();
    bit ok; logic [1:0] id; logic [31:0] y;
    int order[6];
    order = '{0, 1, 2, 3, 0, 3};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h40000000; req_b[i*32 +: 32] = 32'h40400000;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] want;
      want = 4'b0001 << order[k];
      exp_id.push_back(2'(order[k])); exp_y.push_back(32'h40C00000);
      wait_grant(ok);
      n_vec++; if (!ok || req_ready !== want) begin n_err++; $display("FAIL t2_grant%0d: got %b want %b", k, req_ready, want); end
      @(negedge clk);
      if (k == 3) req_valid = 4'b1001;
      if (k == 5) req_valid = 4'b0000;
      n_vec++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL t2_start%0d: got %b want 1", k, mul_start); end
      collect(ok, id, y);
      n_vec++;
      if (!ok || exp_id.size() == 0) begin n_err++; $display("FAIL t2_rsp%0d: got no response want one", k); end
      else begin
        logic [1:0] ei; logic [31:0] ey;
        ei = exp_id.pop_front(); ey = exp_y.pop_front();
        if (id !== ei || y !== ey) begin n_err++; $display("FAIL t2_rsp%0d: got id %0d y %h want id %0d y %h", k, id, y, ei, ey); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    bit ok; logic [1:0] ei; logic [31:0] ey;
    rsp_ready = 1'b0;
    req_a[64 +: 32] = 32'h40000000; req_b[64 +: 32] = 32'h40400000;
    req_valid = 4'b0100;
    exp_id.push_back(2'd2); exp_y.push_back(32'h40C00000);
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0100) begin n_err++; $display("FAIL t3_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
    end
    ei = exp_id.pop_front(); ey = exp_y.pop_front();
    n_vec++; if (!ok) begin n_err++; $display("FAIL t3_rsp_timeout: got none want response"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== ei || rsp_y !== ey || req_ready !== 4'b0000 || mul_start !== 1'b0) begin
        n_err++;
        $display("FAIL t3_hold%0d: got v%b id%0d y%h rr%b st%b want v1 id%0d y%h rr0000 st0", c, rsp_valid, rsp_id, rsp_y, req_ready, mul_start, ei, ey);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL t3_no_grant_handshake: got %b want 0000", req_ready); end
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL t3_release: got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t3_idle_grant: got %b want 0100", req_ready); end
    req_valid = 4'b0000;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL t3_drop: got %b want 0000", req_ready); end
  endtask

  task automatic test_reset_in_wait();
    bit ok; logic [1:0] id; logic [31:0] y;
    @(negedge clk);
    req_a[32 +: 32] = 32'h3F800000; req_b[32 +: 32] = 32'h40A00000;
    req_valid = 4'b0010;
    exp_id.push_back(2'd1); exp_y.push_back(32'h40A00000);
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0010) begin n_err++; $display("FAIL t4_grant_pre: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_id.delete(); exp_y.delete();
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_y !== 32'h0 || mul_start !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL t4_async_reset: got v%b id%0d y%h st%b a%h b%h rr%b want all zero", rsp_valid, rsp_id, rsp_y, mul_start, mul_a, mul_b, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 4'b0010;
    exp_id.push_back(2'd1); exp_y.push_back(32'h40A00000);
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0010) begin n_err++; $display("FAIL t4_grant_post: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    collect(ok, id, y);
    n_vec++;
    if (!ok || exp_id.size() == 0) begin n_err++; $display("FAIL t4_rsp: got no response want one"); end
    else begin
      logic [1:0] ei; logic [31:0] ey;
      ei = exp_id.pop_front(); ey = exp_y.pop_front();
      if (id !== ei || y !== ey) begin n_err++; $display("FAIL t4_rsp: got id %0d y %h want id %0d y %h", id, y, ei, ey); end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_operand();
    bit ok; logic [1:0] id; logic [31:0] y; int s0;
    @(negedge clk);
    s0 = n_starts;
    rsp_ready = 1'b0;
    req_a[31:0] = 32'h00000000; req_b[31:0] = 32'hC0400000;
    req_valid = 4'b0001;
    exp_id.push_back(2'd0); exp_y.push_back(32'h80000000);
    wait_grant(ok);
    n_vec++; if (!ok || req_ready !== 4'b0001) begin n_err++; $display("FAIL t5_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
`ifdef FPMUL_ZERO_BYPASS_EN
    n_vec++; if (rsp_valid !== 1'b1 || mul_start !== 1'b0) begin n_err++; $display("FAIL t5_bypass_latency: got v%b st%b want v1 st0", rsp_valid, mul_start); end
    n_vec++; if (mul_a !== 32'h3F800000) begin n_err++; $display("FAIL t5_mul_a_kept: got %h want 3f800000", mul_a); end
`else
    n_vec++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL t5_start: got %b want 1", mul_start); end
`endif
    collect(ok, id, y);
    n_vec++;
    if (!ok || exp_id.size() == 0) begin n_err++; $display("FAIL t5_rsp: got no response want one"); end
    else begin
      logic [1:0] ei; logic [31:0] ey;
      ei = exp_id.pop_front(); ey = exp_y.pop_front();
      if (id !== ei || y !== ey) begin n_err++; $display("FAIL t5_rsp: got id %0d y %h want id %0d y %h", id, y, ei, ey); end
    end
    @(negedge clk);
`ifdef FPMUL_ZERO_BYPASS_EN
    n_vec++; if (n_starts - s0 !== 0) begin n_err++; $display("FAIL t5_start_count: got %0d want 0", n_starts - s0); end
`else
    n_vec++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL t5_start_count: got %0d want 1", n_starts - s0); end
`endif
  endtask

  task automatic test_busy_block();
    bit ok; logic [1:0] id; logic [31:0] y;
    @(negedge clk);
    force_busy = 1'b1;
    req_a[64 +: 32] = 32'h40000000; req_b[64 +: 32] = 32'h40400000;
    req_valid = 4'b0100;
    exp_id.push_back(2'd2); exp_y.push_back(32'h40C00000);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL t6_blocked%0d: got %b want 0000", c, req_ready); end
      @(negedge clk);
    end
    force_busy = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t6_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    collect(ok, id, y);
    n_vec++;
    if (!ok || exp_id.size() == 0) begin n_err++; $display("FAIL t6_rsp: got no response want one"); end
    else begin
      logic [1:0] ei; logic [31:0] ey;
      ei = exp_id.pop_front(); ey = exp_y.pop_front();
      if (id !== ei || y !== ey) begin n_err++; $display("FAIL t6_rsp: got id %0d y %h want id %0d y %h", id, y, ei, ey); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_in_wait();
    test_zero_operand();
    test_busy_block();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
